// File: rtl/serial_pkg.sv
// Shared constants for bit-serial datapath controllers.
// FSM encodings and default operand width.
package serial_pkg;

    localparam int SERIAL_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The master side offers operands and consumes results.
interface serial_add_ctrl_if
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full-adder cell used by the serial adder.
// Purely combinational.
module serial_add_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one FA cell, LSB first,
// one bit per clock, valid/ready on both operand and result sides.
module serial_add_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_ctrl_if.slave  bus
);

    localparam int IW = $clog2(WIDTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             co_r;
    logic             ov_r;

    logic [IW-1:0]    idx;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last;

    assign idx    = cnt[IW-1:0];
    assign last   = (cnt == LAST);
    assign accept = bus.in_valid & bus.in_ready;

    assign bus.in_ready  = (state == ST_IDLE) |
                           ((state == ST_DONE) & bus.out_ready);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.sum       = sum_r;
    assign bus.c_out     = co_r;
    assign bus.overflow  = ov_r;

    serial_add_ctrl_fa u_fa (
        .a     (a_r[idx]),
        .b     (b_r[idx]),
        .c_in  (carry),
        .sum   (fa_s),
        .c_out (fa_c)
    );

    // Acceptance takes priority so DONE can chain straight into RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            co_r  <= 1'b0;
            ov_r  <= 1'b0;
        end else if (accept) begin
            state <= ST_RUN;
            cnt   <= '0;
            carry <= bus.sub;
            a_r   <= bus.a;
            b_r   <= bus.sub ? ~bus.b : bus.b;
            sum_r <= '0;
        end else begin
            unique case (1'b1)
                (state == ST_RUN): begin
                    sum_r[idx] <= fa_s;
                    carry      <= fa_c;
                    cnt        <= cnt + CW'(1);
                    if (last) begin
                        co_r  <= fa_c;
                        ov_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                 (fa_s != a_r[WIDTH-1]);
                        state <= ST_DONE;
                    end
                end
                (state == ST_DONE): begin
                    if (bus.out_ready) state <= ST_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand set offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port sub  input  1  0 = A+B, 1 = A-B.
REQ-009 SHALL have port out_valid  output  1  result held and valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  WIDTH  result bits.
REQ-012 SHALL have port c_out  output  1  final carry (for subtract: 1 = no borrow).
REQ-013 SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-014 SHALL compute the result bit-serially through one 1-bit full-adder cell, LSB first, one bit per clock.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1; on in_valid, latch a, b (inverted if sub), set carry register to sub, clear bit counter, go to RUN.
REQ-017 RUN: each cycle feed bit[count] of A and effective B plus carry register to the cell, shift sum bit into result register at position count, update carry register, increment count.
REQ-018 RUN: on the cycle processing count = WIDTH-1, capture c_out and overflow, go to DONE.
REQ-019 Handshake latency: operands accepted at edge N yield out_valid=1 after edge N+WIDTH.
REQ-020 DONE: out_valid=1; sum, c_out, overflow SHALL stay stable until out_ready=1.
REQ-021 in_ready SHALL equal (state==IDLE) or (state==DONE and out_ready).
REQ-022 DONE with out_ready=1 and in_valid=0: go to IDLE, out_valid deasserts next cycle.
REQ-023 DONE with out_ready=1 and in_valid=1: result consumed and new operands latched in the same edge, go directly to RUN (no idle bubble).
REQ-024 in_valid while in RUN SHALL be ignored (in_ready=0, no operand capture).
REQ-025 overflow SHALL be 1 iff A[WIDTH-1] equals effective-B[WIDTH-1] and sum[WIDTH-1] differs from them.
REQ-026 sum SHALL be modulo 2^WIDTH; the sub input is sampled only at acceptance.

Reset
REQ-027 rst asserted SHALL immediately force state IDLE, counter 0, carry 0, sum 0, c_out 0, overflow 0, out_valid 0, regardless of clock.
REQ-028 rst during RUN or DONE SHALL discard the operation in progress; no partial result becomes visible.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-030 FSM state encodings and the default WIDTH SHALL live in a shared package/header, serial_pkg, for reuse by other serial datapath controllers.
REQ-031 SHALL instantiate exactly one existing FA cell (a, b, c_in -> c_out, sum) as its only sub-module; no word-wide adder is permitted.
REQ-032 Bit counter width SHALL be $clog2(WIDTH)+1; no other arithmetic beyond the counter increment.

Verification (WIDTH=8)
REQ-033 a=100, b=55, sub=0 -> after 8 RUN cycles sum=155, c_out=0, overflow=1 (signed 100+55 exceeds 127).
REQ-034 a=200, b=100, sub=0 -> sum=44 (0x2C), c_out=1, overflow=0.
REQ-035 a=5, b=7, sub=1 -> sum=0xFE, c_out=0 (borrow), overflow=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, overflow=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> sum/flags stable, in_ready=0; then out_ready=1 with in_valid=1 (a=1, b=1) -> next result 2 exactly 8 cycles later.
REQ-037 Assert rst at RUN cycle 4 of 0xFF+0x01 -> all outputs 0, state IDLE; new request 3+4 -> sum=7, c_out=0.
REQ-038 Pulse in_valid during RUN with different operands -> ignored; original result unchanged.
